// File: rtl/regfile_write_arbiter_pkg.sv
// Purpose: shared register-file types, sizes and the write-enable decoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;

    typedef logic [ADDR_W-1:0]   reg_addr_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [NUM_REGS-1:0] wr_en_t;

    // One-hot write enable for a register address. Register 31 reads as zero,
    // so a write aimed at it produces no enable at all.
    function automatic wr_en_t decode_we(input reg_addr_t addr);
        wr_en_t we;
        we = '0;
        if (int'(addr) != ZERO_REG) begin
            we[addr] = 1'b1;
        end
        return we;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Purpose: bundle of the per-requester writeback valid/ready/addr/data lanes.
// Latency: n/a (wires only).
// Backpressure: requesters hold valid/addr/data stable until they see ready.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Purpose: N-way round-robin arbiter; search starts at ptr and wraps modulo N.
// Latency: purely combinational, grant in the same cycle as valid.
// Backpressure: en=0 suppresses the grant while still reporting the winner index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic found;
    int   j;

    // First valid requester at or after ptr wins; grant is gated by en.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && valid[j]) begin
                found     = 1'b1;
                grant[j]  = en;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register file write port among NUM_REQ writeback sources.
// Latency: accept at edge N drives WriteEnable/WriteData during cycle N..N+1.
// Backpressure: one accept per cycle; freeze or reset withholds every ready.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     freeze,
    regfile_write_arbiter_if.slave   wb,
    output regfile_pkg::wr_en_t      WriteEnable,
    output logic [DATA_W-1:0]        WriteData,
    output regfile_pkg::wr_en_t      pending_mask,
    output logic [CNT_W-1:0]         contention_cnt
);
    import regfile_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [NUM_REQ-1:0] grant;
    logic               arb_en;
    logic               accept;
    logic               contended;

    // Nothing may be accepted while frozen or while reset is held.
    assign arb_en = ~freeze & reset;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .valid     (wb.req_valid),
        .en        (arb_en),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign wb.req_ready = grant;
    assign accept       = |grant;
    assign contended    = ($countones(wb.req_valid) >= 2);
    assign pending_mask = WriteEnable;

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    // Output register: enable is a one-cycle pulse, data holds between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WriteEnable <= '0;
            WriteData   <= '0;
        end else if (accept) begin
            WriteEnable <= decode_we(reg_addr_t'(wb.req_addr[gidx]));
            WriteData   <= wb.req_data[gidx];
        end else begin
            WriteEnable <= '0;
        end
    end

    // Saturating count of accepts made while two or more sources were waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contention_cnt <= '0;
        end else if (accept && contended && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: self-checking bench for regfile_write_arbiter with a write scoreboard.
// Latency: expected writes are queued at the accept and popped one cycle later.
// Backpressure: requesters follow valid/ready; stimulus drops valid after accept.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;
    logic freeze;

    logic [31:0] we;
    logic [63:0] wd;
    logic [31:0] pm;
    logic [15:0] cnt;

    logic [31:0] sat_we;
    logic [63:0] sat_wd;
    logic [31:0] sat_pm;
    logic [3:0]  sat_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] we;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_log[$];

    logic [63:0] regs [32];

    int          m_ptr = 0;
    int          m_cnt = 0;
    int          mon_k;
    int          mon_j;
    logic [2:0]  mon_er;
    exp_t        mon_e;

    regfile_write_arbiter_if #(.NUM_REQ(3), .DATA_W(64), .ADDR_W(5)) wb ();
    regfile_write_arbiter_if #(.NUM_REQ(3), .DATA_W(64), .ADDR_W(5)) sb ();

    regfile_write_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .freeze         (freeze),
        .wb             (wb),
        .WriteEnable    (we),
        .WriteData      (wd),
        .pending_mask   (pm),
        .contention_cnt (cnt)
    );

    regfile_write_arbiter #(.CNT_W(4)) dut_sat (
        .clk            (clk),
        .reset          (reset),
        .freeze         (freeze),
        .wb             (sb),
        .WriteEnable    (sat_we),
        .WriteData      (sat_wd),
        .pending_mask   (sat_pm),
        .contention_cnt (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_we(input logic [4:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a != 5'd31) r = 32'h1 << a;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Register file model written by the DUT's enable/data.
    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (we[i]) regs[i] <= wd;
        end
    end

    assert property (@(negedge clk) disable iff (!reset) $onehot0(we));
    assert property (@(negedge clk) disable iff (!reset) $onehot0(sat_we));

    // Scoreboard monitor: check last cycle's accept, then predict this cycle's.
    always @(negedge clk) begin
        check("we_onehot", 64'($onehot0(we)), 64'd1);
        if (!reset) begin
            sb_q.delete();
            m_ptr = 0;
            m_cnt = 0;
            check("rst_ready", wb.req_ready, 3'b000);
            check("rst_we", we, 32'h0);
            check("rst_cnt", cnt, 16'h0);
        end else begin
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("sb_we", we, mon_e.we);
                check("sb_pending", pm, mon_e.we);
                check("sb_wdata", wd, mon_e.data);
            end else begin
                check("idle_we", we, 32'h0);
            end
            check("cnt", cnt, 16'(m_cnt));
            mon_er = 3'b000;
            mon_k  = -1;
            if (!freeze) begin
                for (int i = 0; i < 3; i++) begin
                    mon_j = (m_ptr + i) % 3;
                    if (mon_k < 0 && wb.req_valid[mon_j]) mon_k = mon_j;
                end
            end
            if (mon_k >= 0) mon_er[mon_k] = 1'b1;
            check("ready", wb.req_ready, mon_er);
            if (mon_k >= 0) begin
                mon_e.we   = exp_we(wb.req_addr[mon_k]);
                mon_e.data = wb.req_data[mon_k];
                sb_q.push_back(mon_e);
                gnt_log.push_back(mon_k);
                if ($countones(wb.req_valid) >= 2 && m_cnt < 65535) m_cnt++;
                m_ptr = (mon_k + 1) % 3;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'h0;
        reset  = 1'b0;
        freeze = 1'b0;
        wb.req_valid = 3'b111;
        wb.req_addr  = {5'd3, 5'd2, 5'd1};
        wb.req_data  = {64'h33, 64'h22, 64'h11};
        sb.req_valid = 3'b000;
        sb.req_addr  = {5'd4, 5'd4, 5'd4};
        sb.req_data  = {64'hA5, 64'hA5, 64'hA5};

        // Reset held with every source valid.
        repeat (3) @(negedge clk);
        check("t1_ready", wb.req_ready, 3'b000);
        check("t1_we", we, 32'h0);
        check("t1_cnt", cnt, 16'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t1_first_grant", wb.req_ready, 3'b001);
        step();
        wb.req_valid = 3'b000;

        // Single write from requester 1.
        wb.req_valid[1] = 1'b1;
        wb.req_addr[1]  = 5'd5;
        wb.req_data[1]  = 64'hDEAD_BEEF;
        @(negedge clk);
        check("t2_ready", wb.req_ready, 3'b010);
        step();
        wb.req_valid = 3'b000;
        @(negedge clk);
        check("t2_ready_drop", wb.req_ready, 3'b000);
        check("t2_we", we, 32'h20);
        check("t2_wd", wd, 64'hDEAD_BEEF);
        step();
        check("t2_reg5", regs[5], 64'hDEAD_BEEF);

        // Round-robin from a fresh pointer.
        reset = 1'b0;
        step();
        reset = 1'b1;
        gnt_log.delete();
        wb.req_addr  = {5'd12, 5'd11, 5'd10};
        wb.req_data  = {64'hC2, 64'hC1, 64'hC0};
        wb.req_valid = 3'b111;
        repeat (6) step();
        wb.req_valid = 3'b000;
        check("t3_ngrants", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
            check($sformatf("t3_grant%0d", i), gnt_log[i], i % 3);
        end
        @(negedge clk);
        check("t3_cnt", cnt, 16'd6);
        step();
        check("t3_reg10", regs[10], 64'hC0);
        check("t3_reg12", regs[12], 64'hC2);

        // Write to the zero register is accepted and discarded.
        wb.req_valid[2] = 1'b1;
        wb.req_addr[2]  = 5'd31;
        wb.req_data[2]  = 64'h1;
        @(negedge clk);
        check("t4_ready", wb.req_ready, 3'b100);
        step();
        wb.req_valid = 3'b000;
        @(negedge clk);
        check("t4_we", we, 32'h0);
        step();
        check("t4_reg31", regs[31], 64'h0);

        // Freeze blocks accepts while the prior write drains.
        wb.req_valid[1] = 1'b1;
        wb.req_addr[1]  = 5'd7;
        wb.req_data[1]  = 64'h77;
        @(negedge clk);
        check("t5_ready_r1", wb.req_ready, 3'b010);
        step();
        wb.req_valid    = 3'b001;
        wb.req_addr[0]  = 5'd8;
        wb.req_data[0]  = 64'h88;
        freeze          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_frozen_ready", wb.req_ready, 3'b000);
            if (i == 0) check("t5_drain_we", we, 32'h80);
            step();
        end
        check("t5_reg7", regs[7], 64'h77);
        freeze = 1'b0;
        @(negedge clk);
        check("t5_unfreeze", wb.req_ready, 3'b001);
        step();
        wb.req_valid = 3'b000;
        step();
        check("t5_reg8", regs[8], 64'h88);

        // Reset right after an accept drops the in-flight write.
        wb.req_valid[1] = 1'b1;
        wb.req_addr[1]  = 5'd9;
        wb.req_data[1]  = 64'h99;
        @(negedge clk);
        check("t5_ready_r1b", wb.req_ready, 3'b010);
        step();
        wb.req_valid = 3'b000;
        check("t5_inflight_we", we, 32'h200);
        reset = 1'b0;
        #1;
        check("t5_rst_we", we, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("t5_reg9", regs[9], 64'h0);

        // Narrow counter saturates instead of wrapping.
        sb.req_valid = 3'b111;
        repeat (10) step();
        @(negedge clk);
        check("t6_cnt10", sat_cnt, 4'd10);
        repeat (10) step();
        @(negedge clk);
        check("t6_cnt_sat", sat_cnt, 4'hF);
        check("t6_sat_we", sat_pm, 32'h10);
        check("t6_sat_wd", sat_wd, 64'hA5);
        check("t6_sat_onehot", 64'($onehot0(sat_we)), 64'd1);
        sb.req_valid = 3'b000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
